inst_buffer_flex: RTL and testbench

Parametrised decoupling FIFO between decode and dispatch; a successor to the fixed-width instruction buffer.
- Configurable depth, write width, read width and packet width.
- Active size and active dispatch lane count change at run time; each takes effect only when the buffer is empty.
- Adds a starvation-driven partial-dispatch mode and an explicit drain request, so residual instructions fewer than the dispatch width leave the buffer without waiting for more fetch.

---
 rtl/inst_buffer_flex.sv | 161 ++++++++++++++++
 tb/tb_inst_buffer_flex.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer_flex.sv
// Decode-to-dispatch decoupling FIFO with run-time size and lane configuration,
// starvation-driven partial dispatch and an explicit drain request.
module inst_buffer_flex #(
  parameter int DEPTH      = 32,
  parameter int WR_WIDTH   = 8,
  parameter int RD_WIDTH   = 4,
  parameter int PKT_W      = 96,
  parameter int STARVE_CYC = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int LW = $clog2(RD_WIDTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic                      stall_i,
  input  logic                      stallFetch_i,
  input  logic                      drain_i,
  input  logic [CW-1:0]             sizeActive_i,
  input  logic [LW-1:0]             rdLanes_i,
  input  logic                      wrReady_i,
  input  logic [WR_WIDTH-1:0]       wrValid_i,
  input  logic [WR_WIDTH*PKT_W-1:0] wrData_i,
  output logic                      full_o,
  output logic [RD_WIDTH-1:0]       rdValid_o,
  output logic [RD_WIDTH*PKT_W-1:0] rdData_o,
  output logic [CW-1:0]             count_o,
  output logic                      cfgPending_o
);

  localparam int SW = (STARVE_CYC > 0) ? $clog2(STARVE_CYC + 1) : 1;

  logic [PKT_W-1:0] mem [DEPTH];

  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] size_reg;
  logic [LW-1:0] lanes_reg;
  logic [SW-1:0] starve_cnt;

  logic          wr_acc;
  logic          wr_any;
  logic          cfg_load;
  logic          size_change;
  logic          starved;
  logic [CW:0]   full_need;
  logic [CW-1:0] wr_num;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_num;
  logic [AW-1:0] wr_addr [WR_WIDTH];
  logic [AW-1:0] rd_addr [RD_WIDTH];
  logic [AW-1:0] head_next;
  logic [AW-1:0] tail_next;
  logic [SW-1:0] starve_next;

  // Circular add over the active size; operands stay below 2*size_reg.
  function automatic logic [AW-1:0] wrap_add(input logic [CW-1:0] base,
                                             input logic [CW-1:0] off,
                                             input logic [CW-1:0] size);
    logic [CW-1:0] sum;
    sum = base + off;
    if (sum >= size) sum = sum - size;
    return sum[AW-1:0];
  endfunction

  // Full is judged on registered count against room for a whole bundle.
  assign full_need    = {1'b0, count} + (CW+1)'(WR_WIDTH);
  assign full_o       = full_need > {1'b0, size_reg};
  assign wr_acc       = wrReady_i & ~full_o & ~stallFetch_i & ~flush_i;
  assign wr_any       = wr_acc & (|wrValid_i);
  assign wr_cnt       = wr_acc ? wr_num : '0;
  assign size_change  = sizeActive_i != size_reg;
  assign cfg_load     = (count == '0) & ~wr_any & ~flush_i;
  assign cfgPending_o = size_change | (rdLanes_i != lanes_reg);
  assign starved      = (STARVE_CYC != 0) && (starve_cnt == SW'(STARVE_CYC));
  assign count_o      = count;

  // Sparse write slots are compacted onto consecutive entries from tail.
  always_comb begin
    logic [CW-1:0] run;
    run = '0;
    for (int i = 0; i < WR_WIDTH; i++) begin
      wr_addr[i] = wrap_add({1'b0, tail_ptr}, run, size_reg);
      run        = run + CW'(wrValid_i[i]);
    end
    wr_num = run;
  end

  always_comb begin
    rd_num = '0;
    if (stall_i || flush_i)
      rd_num = '0;
    else if (count >= CW'(lanes_reg))
      rd_num = CW'(lanes_reg);
    else if (drain_i || starved)
      rd_num = count;
  end

  always_comb begin
    rdValid_o = '0;
    rdData_o  = '0;
    for (int j = 0; j < RD_WIDTH; j++) begin
      rd_addr[j]                     = wrap_add({1'b0, head_ptr}, CW'(j), size_reg);
      rdValid_o[j]                   = CW'(j) < rd_num;
      rdData_o[j*PKT_W +: PKT_W]     = mem[rd_addr[j]];
    end
  end

  assign head_next = wrap_add({1'b0, head_ptr}, rd_num, size_reg);
  assign tail_next = wrap_add({1'b0, tail_ptr}, wr_cnt, size_reg);

  // Starvation only accrues while residual entries wait below the lane count.
  always_comb begin
    starve_next = starve_cnt;
    if ((rd_num != '0) || wr_any || (count == '0))
      starve_next = '0;
    else if (!stall_i && (count < CW'(lanes_reg)) && !starved && (STARVE_CYC != 0))
      starve_next = starve_cnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < WR_WIDTH; i++) begin
        if (wrValid_i[i]) mem[wr_addr[i]] <= wrData_i[i*PKT_W +: PKT_W];
      end
    end
  end

  // Control state; a resize rebases the empty buffer so pointers stay below size.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count      <= '0;
      starve_cnt <= '0;
      size_reg   <= CW'(DEPTH);
      lanes_reg  <= LW'(RD_WIDTH);
    end else if (flush_i) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (cfg_load) begin
        size_reg  <= sizeActive_i;
        lanes_reg <= rdLanes_i;
      end
      if (cfg_load && size_change) begin
        head_ptr <= '0;
        tail_ptr <= '0;
      end else begin
        head_ptr <= head_next;
        tail_ptr <= tail_next;
      end
      count      <= count + wr_cnt - rd_num;
      starve_cnt <= starve_next;
    end
  end

endmodule

// File: tb/tb_inst_buffer_flex.sv
// Randomized and directed bench for inst_buffer_flex against a queue-based model.
module tb_inst_buffer_flex;
  localparam int DEPTH = 32, WR_WIDTH = 8, RD_WIDTH = 4, PKT_W = 96, STARVE_CYC = 4;
  localparam int AW = $clog2(DEPTH), CW = AW + 1, LW = $clog2(RD_WIDTH) + 1;

  logic clk = 1'b0;
  logic reset, flush_i, stall_i, stallFetch_i, drain_i, wrReady_i;
  logic [CW-1:0] sizeActive_i;
  logic [LW-1:0] rdLanes_i;
  logic [WR_WIDTH-1:0] wrValid_i;
  logic [WR_WIDTH*PKT_W-1:0] wrData_i;
  logic full_o, cfgPending_o;
  logic [RD_WIDTH-1:0] rdValid_o;
  logic [RD_WIDTH*PKT_W-1:0] rdData_o;
  logic [CW-1:0] count_o;

  int vectors = 0;
  int miscompares = 0;
  int seq = 0;
  logic [PKT_W-1:0] q[$];
  int m_size, m_lanes, m_starve, m_head, m_tail;

  inst_buffer_flex #(.DEPTH(DEPTH), .WR_WIDTH(WR_WIDTH), .RD_WIDTH(RD_WIDTH),
                     .PKT_W(PKT_W), .STARVE_CYC(STARVE_CYC)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .stall_i(stall_i),
    .stallFetch_i(stallFetch_i), .drain_i(drain_i), .sizeActive_i(sizeActive_i),
    .rdLanes_i(rdLanes_i), .wrReady_i(wrReady_i), .wrValid_i(wrValid_i),
    .wrData_i(wrData_i), .full_o(full_o), .rdValid_o(rdValid_o), .rdData_o(rdData_o),
    .count_o(count_o), .cfgPending_o(cfgPending_o));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_size = DEPTH; m_lanes = RD_WIDTH; m_starve = 0; m_head = 0; m_tail = 0;
  endtask

  task automatic set_idle();
    wrReady_i = 0; wrValid_i = '0; flush_i = 0; stall_i = 0; stallFetch_i = 0; drain_i = 0;
  endtask

  task automatic offer(input logic [WR_WIDTH-1:0] v);
    wrReady_i = 1; wrValid_i = v;
    for (int i = 0; i < WR_WIDTH; i++) begin
      wrData_i[i*PKT_W +: PKT_W] = {32'(seq), $urandom(), $urandom()};
      seq++;
    end
  endtask

  // Check this cycle's outputs against the model, then advance the model one clock.
  task automatic step();
    int cnt, n, pop;
    bit full, wacc, wany, starved;
    logic [RD_WIDTH-1:0] ev;
    #1;
    cnt = q.size();
    full = (cnt + WR_WIDTH) > m_size;
    wacc = wrReady_i && !full && !stallFetch_i && !flush_i;
    wany = wacc && (wrValid_i != 0);
    pop = wacc ? $countones(wrValid_i) : 0;
    starved = (STARVE_CYC != 0) && (m_starve == STARVE_CYC);
    if (stall_i || flush_i) n = 0;
    else if (cnt >= m_lanes) n = m_lanes;
    else if (drain_i || starved) n = cnt;
    else n = 0;
    ev = RD_WIDTH'((1 << n) - 1);
    chk("full", PKT_W'(full_o), PKT_W'(full));
    chk("count", PKT_W'(count_o), PKT_W'(cnt));
    chk("rdValid", PKT_W'(rdValid_o), PKT_W'(ev));
    chk("cfgPending", PKT_W'(cfgPending_o),
        PKT_W'((int'(sizeActive_i) != m_size) || (int'(rdLanes_i) != m_lanes)));
    chk("head", PKT_W'(dut.head_ptr), PKT_W'(m_head));
    chk("tail", PKT_W'(dut.tail_ptr), PKT_W'(m_tail));
    for (int j = 0; j < n; j++)
      chk($sformatf("lane%0d_data", j), rdData_o[j*PKT_W +: PKT_W], q[j]);
    if (flush_i) begin
      q.delete(); m_starve = 0; m_head = 0; m_tail = 0;
    end else begin
      if (n > 0 || wany || cnt == 0) m_starve = 0;
      else if (!stall_i && cnt < m_lanes && m_starve < STARVE_CYC) m_starve++;
      for (int k = 0; k < n; k++) void'(q.pop_front());
      m_head = (m_head + n) % m_size;
      if (wacc)
        for (int i = 0; i < WR_WIDTH; i++)
          if (wrValid_i[i]) q.push_back(wrData_i[i*PKT_W +: PKT_W]);
      m_tail = (m_tail + pop) % m_size;
      if (cnt == 0 && !wany) begin
        if (int'(sizeActive_i) != m_size) begin m_head = 0; m_tail = 0; end
        m_size = int'(sizeActive_i); m_lanes = int'(rdLanes_i);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_all();
    for (int g = 0; g < 30 && q.size() != 0; g++) begin
      set_idle(); drain_i = 1; step();
    end
    chk("drained_empty", PKT_W'(q.size()), '0);
  endtask

  int sizes[6] = '{4, 12, 16, 20, 27, 32};
  int cbefore;
  logic [PKT_W-1:0] s0, s2, s5, s7;

  initial begin
    set_idle(); sizeActive_i = CW'(32); rdLanes_i = LW'(4); wrData_i = '0;
    reset = 1;
    @(posedge clk); @(negedge clk);
    reset = 0; model_reset();
    #1;
    chk("reset_count", PKT_W'(count_o), '0);
    chk("reset_full", PKT_W'(full_o), '0);
    chk("reset_rdValid", PKT_W'(rdValid_o), '0);
    chk("reset_cfgPending", PKT_W'(cfgPending_o), '0);

    // Steady stream of four per cycle with four lanes
    offer(8'h0F); step();
    for (int k = 0; k < 2; k++) begin
      offer(8'h0F); #1;
      chk("stream_count", PKT_W'(count_o), PKT_W'(4));
      chk("stream_rdValid", PKT_W'(rdValid_o), PKT_W'(4'hF));
      step();
    end
    set_idle(); #1;
    chk("stream_count_last", PKT_W'(count_o), PKT_W'(4));
    chk("stream_rdValid_last", PKT_W'(rdValid_o), PKT_W'(4'hF));
    step();
    chk("stream_empty", PKT_W'(count_o), '0);

    // Walk tail to 30, then sparse write 0xA5 across the wrap
    for (int g = 0; g < 40 && m_tail != 30; g++) begin set_idle(); offer(8'h03); step(); end
    chk("tail_at_30", PKT_W'(dut.tail_ptr), PKT_W'(30));
    set_idle(); stall_i = 1; offer(8'hA5);
    cbefore = int'(count_o);
    s0 = wrData_i[0*PKT_W +: PKT_W]; s2 = wrData_i[2*PKT_W +: PKT_W];
    s5 = wrData_i[5*PKT_W +: PKT_W]; s7 = wrData_i[7*PKT_W +: PKT_W];
    step();
    chk("sparse_count", PKT_W'(count_o), PKT_W'(cbefore + 4));
    chk("sparse_tail", PKT_W'(dut.tail_ptr), PKT_W'(2));
    chk("sparse_mem30", dut.mem[30], s0);
    chk("sparse_mem31", dut.mem[31], s2);
    chk("sparse_mem0", dut.mem[0], s5);
    chk("sparse_mem1", dut.mem[1], s7);
    drain_all();

    // Fill to 25: full blocks a further bundle
    for (int k = 0; k < 3; k++) begin set_idle(); stall_i = 1; offer(8'hFF); step(); end
    set_idle(); stall_i = 1; offer(8'h01); step();
    set_idle(); stall_i = 1; offer(8'hFF); #1;
    chk("full_at_25", PKT_W'(full_o), PKT_W'(1));
    chk("count_25", PKT_W'(count_o), PKT_W'(25));
    step();
    chk("count_stays_25", PKT_W'(count_o), PKT_W'(25));
    drain_all();

    // Two residual entries: partial dispatch after starvation, then via drain
    set_idle(); offer(8'h03); step();
    for (int k = 0; k < 5; k++) begin
      set_idle(); #1;
      chk($sformatf("starve_rdValid_c%0d", k), PKT_W'(rdValid_o), PKT_W'((k < 4) ? 0 : 3));
      step();
    end
    chk("starve_empty", PKT_W'(count_o), '0);
    set_idle(); offer(8'h03); step();
    set_idle(); drain_i = 1; #1;
    chk("drain_rdValid", PKT_W'(rdValid_o), PKT_W'(3));
    step();
    chk("drain_empty", PKT_W'(count_o), '0);

    // Resize to 16 while occupied
    set_idle(); stall_i = 1; offer(8'h1F); step();
    sizeActive_i = CW'(16);
    for (int k = 0; k < 2; k++) begin
      set_idle(); stall_i = 1; #1;
      chk("resize_pending", PKT_W'(cfgPending_o), PKT_W'(1));
      step();
    end
    for (int g = 0; g < 20 && cfgPending_o; g++) begin set_idle(); step(); end
    chk("resize_applied", PKT_W'(cfgPending_o), '0);
    chk("size_reg_16", PKT_W'(dut.size_reg), PKT_W'(16));
    for (int k = 0; k < 40; k++) begin
      set_idle();
      if ($urandom_range(0, 1) == 1) offer(8'($urandom_range(1, 255)));
      stall_i = ($urandom_range(0, 3) == 0);
      step();
      chk("tail_below_16", PKT_W'(dut.tail_ptr < 16), PKT_W'(1));
    end
    drain_all();

    // Flush beats a simultaneous write and dispatch
    set_idle(); stall_i = 1; offer(8'hFF); step();
    set_idle(); flush_i = 1; offer(8'hFF); #1;
    chk("flush_rdValid", PKT_W'(rdValid_o), '0);
    step();
    chk("flush_count", PKT_W'(count_o), '0);
    chk("flush_head", PKT_W'(dut.head_ptr), '0);
    chk("flush_tail", PKT_W'(dut.tail_ptr), '0);

    // Asynchronous reset between edges
    sizeActive_i = CW'(32); set_idle(); step();
    set_idle(); stall_i = 1; offer(8'hFF); step();
    set_idle(); stall_i = 1; #2;
    reset = 1; #1;
    chk("async_count", PKT_W'(count_o), '0);
    chk("async_full", PKT_W'(full_o), '0);
    chk("async_rdValid", PKT_W'(rdValid_o), '0);
    chk("async_cfgPending", PKT_W'(cfgPending_o), '0);
    reset = 0; model_reset(); set_idle();
    @(negedge clk);

    // Randomized traffic with occasional reconfiguration
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      if ($urandom_range(0, 99) < 2) sizeActive_i = CW'(sizes[$urandom_range(0, 5)]);
      if ($urandom_range(0, 99) < 2) rdLanes_i = LW'($urandom_range(1, RD_WIDTH));
      if ($urandom_range(0, 99) < 60) offer(8'($urandom_range(1, 255)));
      stall_i      = ($urandom_range(0, 99) < 20);
      stallFetch_i = ($urandom_range(0, 99) < 10);
      drain_i      = ($urandom_range(0, 99) < 8);
      flush_i      = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
